// File: rtl/uut_test_sequencer.sv
// Drives one Twofish test vector through the UUT: loads key/block/flags/expected
// from a byte stream, resets and times the UUT, then streams a 5-byte result record.
module uut_test_sequencer #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         rst_uut,
  output logic [127:0] key_uut,
  output logic [127:0] block_i_uut,
  output logic         encdec_uut,
  input  logic [127:0] block_o_uut,
  input  logic         end_signal_uut,
  output logic [2:0]   dbg_state
);

  // Handshakes: a byte moves on a clock edge where valid and ready are both high;
  // the source holds its byte steady until that edge.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RST_UUT = 3'd2,
    S_RUN     = 3'd3,
    S_CHECK   = 3'd4,
    S_REPORT  = 3'd5
  } state_t;

  localparam logic [31:0] LP_TIMEOUT  = 32'(TIMEOUT);
  localparam logic [31:0] LP_RST_LAST = 32'(RST_CYCLES - 1);

  state_t         r_state;
  logic [5:0]     r_idx;
  logic [127:0]   r_key;
  logic [127:0]   r_block;
  logic           r_encdec;
  logic [127:0]   r_expected;
  logic [127:0]   r_captured;
  logic [31:0]    r_counter;
  logic [31:0]    r_cycles;
  logic [31:0]    r_rst_cnt;
  logic           r_timeout;
  logic           r_mismatch;
  logic           r_rst_uut;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [7:0]     r_out_byte;
  logic           r_busy;
  logic           r_done;

  logic           w_load_fire;
  logic           w_out_fire;
  logic           w_mismatch;
  logic [5:0]     w_next_idx;
  logic [7:0]     w_status;
  logic [7:0]     w_next_byte;

  function automatic logic [7:0] rec_byte(input logic [7:0] status,
                                          input logic [31:0] cyc,
                                          input logic [2:0] k);
    case (k)
      3'd0:    return status;
      3'd1:    return cyc[31:24];
      3'd2:    return cyc[23:16];
      3'd3:    return cyc[15:8];
      3'd4:    return cyc[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign w_load_fire = in_valid & r_in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_mismatch  = (r_captured != r_expected);
  assign w_next_idx  = r_idx + 6'd1;
  assign w_status    = {6'b0, r_timeout, r_mismatch};
  assign w_next_byte = rec_byte(w_status, r_cycles, w_next_idx[2:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 6'd0;
      r_key       <= '0;
      r_block     <= '0;
      r_encdec    <= 1'b0;
      r_expected  <= '0;
      r_captured  <= '0;
      r_counter   <= 32'd0;
      r_cycles    <= 32'd0;
      r_rst_cnt   <= 32'd0;
      r_timeout   <= 1'b0;
      r_mismatch  <= 1'b0;
      r_rst_uut   <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rst_uut <= 1'b1;
          if (start) begin
            r_state    <= S_LOAD;
            r_idx      <= 6'd0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_load_fire) begin
            // Each field is a shift register, so the first byte ends up in the MSBs.
            if (r_idx < 6'd16)       r_key      <= {r_key[119:0], in_byte};
            else if (r_idx < 6'd32)  r_block    <= {r_block[119:0], in_byte};
            else if (r_idx == 6'd32) r_encdec   <= in_byte[0];
            else                     r_expected <= {r_expected[119:0], in_byte};
            if (r_idx == 6'd48) begin
              r_state    <= S_RST_UUT;
              r_in_ready <= 1'b0;
              r_rst_cnt  <= 32'd0;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
        S_RST_UUT: begin
          r_rst_uut <= 1'b1;
          if (r_rst_cnt == LP_RST_LAST) begin
            r_state   <= S_RUN;
            r_rst_uut <= 1'b0;
            r_counter <= 32'd0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // Completion is checked before the timeout so a late finish still counts.
          if (end_signal_uut) begin
            r_cycles   <= r_counter;
            r_captured <= block_o_uut;
            r_state    <= S_CHECK;
          end else if (r_counter == LP_TIMEOUT) begin
            r_timeout   <= 1'b1;
            r_mismatch  <= 1'b0;
            r_cycles    <= LP_TIMEOUT;
            r_state     <= S_REPORT;
            r_rst_uut   <= 1'b1;
            r_out_valid <= 1'b1;
            r_out_byte  <= 8'h02;
            r_idx       <= 6'd0;
          end else begin
            r_counter <= r_counter + 32'd1;
          end
        end
        S_CHECK: begin
          r_mismatch  <= w_mismatch;
          r_timeout   <= 1'b0;
          r_state     <= S_REPORT;
          r_rst_uut   <= 1'b1;
          r_out_valid <= 1'b1;
          r_out_byte  <= {7'b0, w_mismatch};
          r_idx       <= 6'd0;
        end
        S_REPORT: begin
          r_rst_uut <= 1'b1;
          if (w_out_fire) begin
            if (r_idx == 6'd4) begin
              r_out_valid <= 1'b0;
              r_out_byte  <= 8'h00;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_idx      <= w_next_idx;
              r_out_byte <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_byte    = r_out_byte;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rst_uut     = r_rst_uut;
  assign key_uut     = r_key;
  assign block_i_uut = r_block;
  assign encdec_uut  = r_encdec;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uut_test_sequencer.sv
// Randomized bench for uut_test_sequencer: a simple UUT model, a byte driver,
// and a record scoreboard fed by a reference model of the result rules.
module tb_uut_test_sequencer;

  localparam int TO = 100;
  localparam logic [127:0] KAT = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_ready, out_valid, out_ready;
  logic         busy, done, rst_uut, encdec_uut, end_signal_uut;
  logic [7:0]   in_byte, out_byte;
  logic [127:0] key_uut, block_i_uut, block_o_uut;
  logic [2:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  int           uut_cnt = 0;
  int           uut_delay = 0;
  bit           uut_never = 1'b0;
  logic [127:0] uut_ret = '0;
  logic [127:0] cur_key = '0, cur_block = '0;
  logic         cur_enc = 1'b0;
  int           ready_mode = 0;

  always #5 clk = ~clk;

  uut_test_sequencer #(.RST_CYCLES(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .rst_uut(rst_uut),
    .key_uut(key_uut), .block_i_uut(block_i_uut), .encdec_uut(encdec_uut),
    .block_o_uut(block_o_uut), .end_signal_uut(end_signal_uut),
    .dbg_state(dbg_state)
  );

  // UUT model: finishes uut_delay clocks after its reset is released.
  always @(posedge clk) begin
    if (rst_uut) uut_cnt <= 0;
    else         uut_cnt <= uut_cnt + 1;
  end
  assign end_signal_uut = !rst_uut && !uut_never && (uut_cnt >= uut_delay);
  assign block_o_uut    = uut_ret;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Reference model: the record the sequencer must emit for one run.
  task automatic push_record(input int delay, input bit never,
                             input logic [127:0] ret, input logic [127:0] exp);
    logic [7:0]  st;
    logic [31:0] cyc;
    if (never || delay > TO) begin
      st  = 8'h02;
      cyc = TO;
    end else begin
      st  = (ret != exp) ? 8'h01 : 8'h00;
      cyc = delay;
    end
    exp_q.push_back(st);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'((cyc >> (8 * k)) & 32'hFF));
  endtask

  task automatic send_vector(input logic [127:0] key, input logic [127:0] blk,
                             input logic [7:0] flags, input logic [127:0] exp,
                             input int gap_max, input bit start_mid);
    logic [7:0] vb[49];
    logic       rdy;
    int         guard;
    cur_key = key; cur_block = blk; cur_enc = flags[0];
    for (int i = 0; i < 16; i++) begin
      vb[i]      = key[127 - 8 * i -: 8];
      vb[16 + i] = blk[127 - 8 * i -: 8];
      vb[33 + i] = exp[127 - 8 * i -: 8];
    end
    vb[32] = flags;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 49; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (start_mid && i == 10) start = 1'b1;
      in_valid = 1'b1;
      in_byte  = vb[i];
      guard    = 0;
      do begin
        rdy = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end while (!rdy && guard < 100);
      check("in_accept", rdy, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check(name, (exp_q.size() == 0 && !busy), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input string name, input logic [127:0] key,
                            input logic [127:0] blk, input logic [7:0] flags,
                            input logic [127:0] exp, input int delay, input bit never,
                            input logic [127:0] ret, input int gap_max, input bit start_mid);
    uut_delay = delay; uut_never = never; uut_ret = ret;
    push_record(delay, never, ret, exp);
    send_vector(key, blk, flags, exp, gap_max, start_mid);
    wait_idle(name);
  endtask

  // out_ready driver: always ready, three stall cycles per byte, or random.
  initial begin
    int stall_cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        if (out_valid && stall_cnt >= 3) begin
          out_ready = 1'b1;
          stall_cnt = 0;
        end else begin
          out_ready = 1'b0;
          if (out_valid) stall_cnt++;
        end
      end else if (ready_mode == 2) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every consumed record byte.
  initial begin
    bit         prev_stall = 1'b0;
    bit         done_due   = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic [7:0] e;
    int         mon_pos    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0; done_due = 1'b0; mon_pos = 0;
      end else begin
        if (done_due) begin
          check("done_pulse", done, 1);
          done_due = 1'b0;
        end else if (done) begin
          check("done_spurious", done, 0);
        end
        if (out_valid) begin
          check("rst_uut_in_report", rst_uut, 1);
          if (prev_stall) check("byte_stable", out_byte, prev_byte);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_byte: got %h required none", out_byte);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("rec_byte%0d", mon_pos), out_byte, e);
            end
            if (mon_pos == 0) begin
              check("key_uut", key_uut, cur_key);
              check("block_i_uut", block_i_uut, cur_block);
              check("encdec_uut", encdec_uut, cur_enc);
            end
            if (mon_pos == 4) begin
              mon_pos  = 0;
              done_due = 1'b1;
            end else begin
              mon_pos++;
            end
          end
          prev_stall = !out_ready;
          prev_byte  = out_byte;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    logic [127:0] rk, rb, rexp, rret;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;

    // T1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rst_uut", rst_uut, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_done", done, 0);
    check("rst_key", key_uut, 0);
    check("rst_block", block_i_uut, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T2 pass, T3 mismatch, T4 timeout, then end-on-first-cycle and end-at-TIMEOUT
    run_vector("t2_pass", '0, '0, 8'h00, KAT, 20, 1'b0, KAT, 0, 1'b0);
    run_vector("t3_mismatch", '0, '0, 8'h00, KAT, 7, 1'b0, KAT ^ 128'h1, 0, 1'b0);
    run_vector("t4_timeout", '0, '0, 8'h01, KAT, 0, 1'b1, KAT, 0, 1'b0);
    run_vector("end_first_cycle", '0, '0, 8'hFE, KAT, 0, 1'b0, KAT, 0, 1'b0);
    run_vector("end_at_timeout", '0, '0, 8'hFF, KAT, TO, 1'b0, KAT ^ 128'h80, 0, 1'b0);

    // T5: input gaps, output stalls, stray start mid-load
    ready_mode = 1;
    run_vector("t5_stalls", '0, '0, 8'h00, KAT, 20, 1'b0, KAT, 3, 1'b1);
    ready_mode = 0;

    // T6: reset during RUN abandons the vector
    uut_never = 1'b1;
    send_vector({4{32'hDEADBEEF}}, {4{32'h01234567}}, 8'h01, KAT, 0, 1'b0);
    g = 0;
    while (rst_uut && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("t6_reached_run", rst_uut, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_rst_uut", rst_uut, 1);
    check("t6_in_ready", in_ready, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_key_cleared", key_uut, 0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_record", out_valid, 0);
    run_vector("t6_recover", {4{32'hDEADBEEF}}, {4{32'h01234567}}, 8'h01, KAT,
               33, 1'b0, KAT, 0, 1'b0);

    // Random vectors with random delays (some past TIMEOUT) and random back-pressure
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      rexp = {$urandom, $urandom, $urandom, $urandom};
      rret = ($urandom_range(0, 1) != 0) ? rexp : {$urandom, $urandom, $urandom, $urandom};
      run_vector($sformatf("rand%0d", n), rk, rb, 8'($urandom), rexp,
                 int'($urandom_range(0, TO + 10)), 1'b0, rret, 2, 1'b0);
    end
    ready_mode = 0;

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
